// File: rtl/booth_mac_acc.sv
// Saturating multiply-accumulate stage: sums ACC_LEN signed products per result
// and presents each result on a valid/ready port, flagging products dropped while stalled.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_ACCUM | accepting products into the partial sum
// ST_OUT   | result held on acc_out until acc_valid && acc_ready
module booth_mac_acc #(
  parameter int PROD_W  = 33,
  parameter int ACC_W   = 40,
  parameter int ACC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] product_in,
  input  logic              product_valid,
  input  logic              clear,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_sat,
  output logic              drop_err,
  output logic [7:0]        count
);

  typedef enum logic {ST_ACCUM, ST_OUT} state_t;

  localparam logic [7:0]       LAST    = 8'(ACC_LEN - 1);
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         count_q, count_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               acc_valid_q, acc_valid_d;
  logic               acc_sat_q, acc_sat_d;
  logic               drop_err_q, drop_err_d;
  logic               sat_trk_q, sat_trk_d;

  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   sum_sat;
  logic               ovf;

  // One guard bit above the accumulator; overflow shows as guard != MSB.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-PROD_W){product_in[PROD_W-1]}}, product_in};
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!ovf)
      sum_sat = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W])
      sum_sat = SAT_MIN;
    else
      sum_sat = SAT_MAX;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    acc_sat_d   = acc_sat_q;
    drop_err_d  = drop_err_q;
    sat_trk_d   = sat_trk_q;
    if (clear) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      count_d     = '0;
      acc_valid_d = 1'b0;
      acc_sat_d   = 1'b0;
      drop_err_d  = 1'b0;
      sat_trk_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (product_valid) begin
            if (count_q == LAST) begin
              acc_out_d   = sum_sat;
              acc_sat_d   = sat_trk_q | ovf;
              acc_valid_d = 1'b1;
              acc_d       = '0;
              count_d     = '0;
              sat_trk_d   = 1'b0;
              state_d     = ST_OUT;
            end else begin
              acc_d     = sum_sat;
              count_d   = count_q + 8'd1;
              sat_trk_d = sat_trk_q | ovf;
            end
          end
        end
        ST_OUT: begin
          if (product_valid) drop_err_d = 1'b1;
          if (acc_ready) begin
            acc_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      acc_sat_q   <= 1'b0;
      drop_err_q  <= 1'b0;
      sat_trk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      acc_sat_q   <= acc_sat_d;
      drop_err_q  <= drop_err_d;
      sat_trk_q   <= sat_trk_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM) && !clear;
  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign acc_sat   = acc_sat_q;
  assign drop_err  = drop_err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: three instances cover the default
// configuration, a 34-bit accumulator for backpressure, and ACC_LEN=3 for saturation.
module tb_booth_mac_acc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // u0: defaults (PROD_W=33, ACC_W=40, ACC_LEN=4)
  logic [32:0] pi0 = '0;
  logic        pv0 = 1'b0, clr0 = 1'b0, rdy0 = 1'b1;
  logic        inr0, av0, as0, de0;
  logic [39:0] ao0;
  logic [7:0]  cnt0;

  // u1: ACC_W=34, ACC_LEN=4
  logic [32:0] pi1 = '0;
  logic        pv1 = 1'b0, clr1 = 1'b0, rdy1 = 1'b0;
  logic        inr1, av1, as1, de1;
  logic [33:0] ao1;
  logic [7:0]  cnt1;

  // u2: ACC_W=34, ACC_LEN=3
  logic [32:0] pi2 = '0;
  logic        pv2 = 1'b0, clr2 = 1'b0, rdy2 = 1'b1;
  logic        inr2, av2, as2, de2;
  logic [33:0] ao2;
  logic [7:0]  cnt2;

  booth_mac_acc u0 (
    .clk(clk), .rst(rst), .product_in(pi0), .product_valid(pv0), .clear(clr0),
    .in_ready(inr0), .acc_out(ao0), .acc_valid(av0), .acc_ready(rdy0),
    .acc_sat(as0), .drop_err(de0), .count(cnt0)
  );

  booth_mac_acc #(.PROD_W(33), .ACC_W(34), .ACC_LEN(4)) u1 (
    .clk(clk), .rst(rst), .product_in(pi1), .product_valid(pv1), .clear(clr1),
    .in_ready(inr1), .acc_out(ao1), .acc_valid(av1), .acc_ready(rdy1),
    .acc_sat(as1), .drop_err(de1), .count(cnt1)
  );

  booth_mac_acc #(.PROD_W(33), .ACC_W(34), .ACC_LEN(3)) u2 (
    .clk(clk), .rst(rst), .product_in(pi2), .product_valid(pv2), .clear(clr2),
    .in_ready(inr2), .acc_out(ao2), .acc_valid(av2), .acc_ready(rdy2),
    .acc_sat(as2), .drop_err(de2), .count(cnt2)
  );

  // Inputs change just after a falling edge; the task returns at the next
  // falling edge, after the rising edge that consumed the pulse.
  task automatic send0(input logic [32:0] v);
    pi0 = v; pv0 = 1'b1;
    @(negedge clk);
    pv0 = 1'b0;
  endtask

  task automatic send1(input logic [32:0] v);
    pi1 = v; pv1 = 1'b1;
    @(negedge clk);
    pv1 = 1'b0;
  endtask

  task automatic send2(input logic [32:0] v);
    pi2 = v; pv2 = 1'b1;
    @(negedge clk);
    pv2 = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (av0 !== 1'b0 || ao0 !== 40'd0 || cnt0 !== 8'd0 || de0 !== 1'b0 || as0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: av=%b ao=%0d cnt=%0d de=%b as=%b, expected all 0", av0, ao0, cnt0, de0, as0);
    end
    tests_run++;
    if (inr0 !== 1'b1 || inr1 !== 1'b1 || inr2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b%b%b expected 111", inr0, inr1, inr2);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_square_sum;
    for (int i = 0; i < 4; i++) begin
      send0(33'd122389969);
      if (i < 3) begin
        tests_run++;
        if (cnt0 !== 8'(i + 1) || av0 !== 1'b0) begin
          tests_failed++;
          $display("FAIL square_partial%0d: cnt=%0d av=%b expected cnt=%0d av=0", i, cnt0, av0, i + 1);
        end
        repeat (3) @(negedge clk);
      end
    end
    tests_run++;
    if (av0 !== 1'b1 || ao0 !== 40'd489559876 || as0 !== 1'b0 || cnt0 !== 8'd0) begin
      tests_failed++;
      $display("FAIL square_result: av=%b ao=%0d as=%b cnt=%0d expected 1 489559876 0 0", av0, ao0, as0, cnt0);
    end
    @(negedge clk);
    tests_run++;
    if (av0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL square_single_valid: av=%b expected 0", av0);
    end
  endtask

  task automatic test_mixed_sign;
    send0(33'd100);
    send0(-33'sd250);
    send0(33'd7);
    send0(-33'sd1);
    tests_run++;
    if (av0 !== 1'b1 || ao0 !== 40'hFF_FFFF_FF70 || as0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mixed_sign: av=%b ao=%h as=%b expected 1 ffffffff70 0", av0, ao0, as0);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    rdy1 = 1'b0;
    send1(33'd1); send1(33'd2); send1(33'd3); send1(33'd4);
    tests_run++;
    if (av1 !== 1'b1 || ao1 !== 34'd10 || inr1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_first_result: av=%b ao=%0d inr=%b expected 1 10 0", av1, ao1, inr1);
    end
    send1(33'd50);
    send1(33'd60);
    repeat (2) @(negedge clk);
    tests_run++;
    if (av1 !== 1'b1 || ao1 !== 34'd10 || de1 !== 1'b1 || cnt1 !== 8'd0) begin
      tests_failed++;
      $display("FAIL bp_held: av=%b ao=%0d de=%b cnt=%0d expected 1 10 1 0", av1, ao1, de1, cnt1);
    end
    rdy1 = 1'b1;
    send1(33'd70);
    rdy1 = 1'b0;
    tests_run++;
    if (av1 !== 1'b0 || cnt1 !== 8'd0 || inr1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_handshake: av=%b cnt=%0d inr=%b expected 0 0 1", av1, cnt1, inr1);
    end
    send1(33'd10); send1(33'd20); send1(33'd30); send1(33'd40);
    tests_run++;
    if (av1 !== 1'b1 || ao1 !== 34'd100 || as1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_second_result: av=%b ao=%0d as=%b expected 1 100 0", av1, ao1, as1);
    end
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) send2(33'h0_FFFF_FFFF);
    tests_run++;
    if (av2 !== 1'b1 || ao2 !== 34'h1_FFFF_FFFF || as2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_pos: av=%b ao=%h as=%b expected 1 1ffffffff 1", av2, ao2, as2);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) send2(33'h1_0000_0000);
    tests_run++;
    if (av2 !== 1'b1 || ao2 !== 34'h2_0000_0000 || as2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_neg: av=%b ao=%h as=%b expected 1 200000000 1", av2, ao2, as2);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) send2(33'd1);
    tests_run++;
    if (av2 !== 1'b1 || ao2 !== 34'd3 || as2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_recover: av=%b ao=%0d as=%b expected 1 3 0", av2, ao2, as2);
    end
    @(negedge clk);
  endtask

  task automatic test_clear;
    send0(33'd5);
    send0(33'd5);
    tests_run++;
    if (cnt0 !== 8'd2) begin
      tests_failed++;
      $display("FAIL clear_pre_count: cnt=%0d expected 2", cnt0);
    end
    clr0 = 1'b1; pi0 = 33'd5; pv0 = 1'b1;
    #1;
    tests_run++;
    if (inr0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_in_ready: inr=%b expected 0", inr0);
    end
    @(negedge clk);
    clr0 = 1'b0; pv0 = 1'b0;
    tests_run++;
    if (cnt0 !== 8'd0 || de0 !== 1'b0 || av0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_state: cnt=%0d de=%b av=%b expected 0 0 0", cnt0, de0, av0);
    end
    for (int i = 0; i < 4; i++) send0(33'd5);
    tests_run++;
    if (av0 !== 1'b1 || ao0 !== 40'd20) begin
      tests_failed++;
      $display("FAIL clear_next_result: av=%b ao=%0d expected 1 20", av0, ao0);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    rdy0 = 1'b0;
    for (int i = 0; i < 4; i++) send0(33'd1);
    send0(33'd9);
    tests_run++;
    if (av0 !== 1'b1 || ao0 !== 40'd4 || de0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_pre: av=%b ao=%0d de=%b expected 1 4 1", av0, ao0, de0);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (av0 !== 1'b0 || ao0 !== 40'd0 || de0 !== 1'b0 || cnt0 !== 8'd0) begin
      tests_failed++;
      $display("FAIL arst_immediate: av=%b ao=%0d de=%b cnt=%0d expected all 0", av0, ao0, de0, cnt0);
    end
    @(negedge clk);
    rst = 1'b0;
    rdy0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send0(33'd2);
    tests_run++;
    if (av0 !== 1'b1 || ao0 !== 40'd8 || de0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_resume: av=%b ao=%0d de=%b expected 1 8 0", av0, ao0, de0);
    end
    @(negedge clk);
    tests_run++;
    if (av0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_resume_ack: av=%b expected 0", av0);
    end
  endtask

  initial begin
    test_reset();
    test_square_sum();
    test_mixed_sign();
    test_backpressure();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/booth_mac_acc.md
Name: booth_mac_acc

Overview:
- Downstream stage of the Booth multiplier top. Consumes the signed 33-bit product and its completion pulse.
- Accumulates a fixed number of products into a wide saturating signed accumulator, then presents the sum on a valid/ready output port.
- Turns the single-shot multiplier into a dot-product/MAC datapath. Detects products dropped while the output is stalled.

Parameters:
- PROD_W, 33, width of signed product input (matches multiplier result width)
- ACC_W, 40, width of signed accumulator and result; must be >= PROD_W+1
- ACC_LEN, 4, number of products summed per result; range 1..255

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- product_in  in  PROD_W  signed two's-complement product from multiplier
- product_valid  in  1  one-cycle pulse: product_in valid this cycle
- clear  in  1  synchronous abort; discards partial sum and pending result
- in_ready  out  1  combinational; 1 when a product_valid this cycle will be accepted
- acc_out  out  ACC_W  signed accumulated result
- acc_valid  out  1  acc_out valid; held until acc_ready
- acc_ready  in  1  downstream accepts acc_out when acc_valid && acc_ready
- acc_sat  out  1  saturation occurred during this result's accumulation; qualified by acc_valid
- drop_err  out  1  sticky; a product_valid arrived while in_ready=0
- count  out  8  products accepted into current partial sum

Behaviour:
- Reset (rst=1, async): state=ACCUM, internal acc=0, count=0, acc_out=0, acc_valid=0, acc_sat=0, drop_err=0, sat tracker=0.
- States: ACCUM, OUT. in_ready = (state==ACCUM) && !clear.
- ACCUM, product_valid=1:
  - sum = acc + sign_extend(product_in), computed in ACC_W+1 bits.
  - On positive overflow, clamp to 2^(ACC_W-1)-1; on negative overflow, clamp to -2^(ACC_W-1). Either clamp sets the sat tracker.
  - If count < ACC_LEN-1: acc<=sum, count++.
  - If count == ACC_LEN-1: acc_out<=sum, acc_sat<=sat tracker OR this cycle's clamp, acc_valid<=1, acc<=0, count<=0, sat tracker<=0, state<=OUT.
- Latency: acc_valid rises on the clock edge that registers the ACC_LEN-th accepted product, i.e. visible the cycle after that product_valid.
- ACCUM, product_valid=0: hold everything.
- OUT:
  - acc_out, acc_sat and acc_valid are held stable until acc_valid && acc_ready.
  - On that handshake: acc_valid<=0, state<=ACCUM. acc_out keeps its last value; it is don't-care while acc_valid=0.
  - product_valid in OUT (including the handshake cycle) is dropped: no accumulation, drop_err<=1.
- ACC_LEN=1: every accepted product goes straight to OUT. Accumulation never carries across results; each result starts from 0.
- clear=1 (sync) has highest priority below rst. It forces acc=0, count=0, sat tracker=0, acc_valid=0, acc_sat=0, drop_err=0, state=ACCUM.
  - A product_valid in the same cycle is ignored and not flagged.
  - A pending unacknowledged result is discarded.
- rst mid-accumulation or mid-OUT: immediate return to reset values. The partial sum is lost.
- Sign extension uses product_in[PROD_W-1]. The value -2^(PROD_W-1) is treated as a legal input.
- No combinational path from product_in to any output. in_ready depends only on state and clear.

Test Plan:
- Reset then 4 pulses of product_in=122389969 (-11063 x -11063), 3 idle cycles between each, acc_ready=1 -> acc_valid one cycle after 4th pulse, acc_out=489559876, acc_sat=0, count back to 0, single-cycle acc_valid.
- Mixed signs: products +100, -250, +7, -1 -> acc_out=-144 (ACC_W bits all-ones upper), acc_sat=0.
- Backpressure: ACC_W=34, acc_ready=0 after result, then 2 more product_valid pulses -> acc_out/acc_valid held, drop_err=1. Raise acc_ready -> acc_valid drops next cycle, next result counts only post-handshake products.
- Saturation: ACC_W=34, ACC_LEN=3, three products of 4294967295 -> acc_out=8589934591, acc_sat=1. Then three products of -4294967296 -> acc_out=-8589934592, acc_sat=1. Then next result of 1,1,1 -> acc_out=3, acc_sat=0.
- clear after 2 of 4 products, plus product_valid same cycle -> count=0, no drop_err. Next 4 products of 5 -> acc_out=20.
- Assert rst asynchronously mid-OUT, between clock edges -> acc_valid, acc_out, drop_err, count all 0 before the next edge. Operation resumes normally after deassert.
